writeback_unit: RTL and testbench
=================================

Name: writeback_unit

Overview:
- Initiator side of the integer register file write port.
- Collects completed results from two producers and drives one registered write per cycle onto the register file's rd/wen/dataD port:
  - the ALU: single-cycle, no backpressure;
  - the load/store unit (LSU): valid/ready, buffered in a small FIFO.
- Keeps a per-register pending scoreboard. Issue logic sets a bit when it dispatches an instruction; the bit clears on writeback. Hazard detection reads the scoreboard.

Parameters:
- ADDR_WIDTH, 5, register index width; the file has 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register data width.
- DEPTH, 4, LSU result FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  an instruction with a destination is dispatched this cycle.
- iss_rd  in  ADDR_WIDTH  destination of the dispatched instruction.
- alu_valid  in  1  ALU result present this cycle; always accepted.
- alu_rd  in  ADDR_WIDTH  ALU result destination.
- alu_data  in  DATA_WIDTH  ALU result value.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  FIFO can accept; equals !full.
- lsu_rd  in  ADDR_WIDTH  LSU result destination.
- lsu_data  in  DATA_WIDTH  LSU result value.
- rf_wen  out  1  register file write enable, registered.
- rf_rd  out  ADDR_WIDTH  register file write index, registered.
- rf_data  out  DATA_WIDTH  register file write data, registered.
- pending  out  2**ADDR_WIDTH  scoreboard; bit i set means xi has an outstanding write.
- fifo_count  out  $clog2(DEPTH)+1  current LSU FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_rd=0, rf_data=0, pending=0, fifo_count=0, lsu_ready=1.
  - FIFO pointers reset to 0.
  - Reset mid-operation discards all buffered LSU results and all pending bits.
- LSU FIFO:
  - Enqueue on an edge with lsu_valid && lsu_ready.
  - lsu_ready depends only on full (fifo_count==DEPTH). No lookahead: when full, ready stays 0 that cycle even if a dequeue happens.
  - Pointers wrap modulo DEPTH. Simultaneous enqueue and dequeue leaves the count unchanged.
  - LSU data is never written directly, even when the FIFO is empty. Minimum LSU latency is 2 cycles: enqueue edge, select edge, then rf_wen high.
- Selection at each edge:
  - If alu_valid: the ALU result is selected; the FIFO head is held.
  - Else if the FIFO is not empty: the head is selected and dequeued.
  - Else: nothing is selected.
  - The selection is registered. rf_wen/rf_rd/rf_data show the selected write during the following cycle, and the register file commits it at the end of that cycle.
- x0 rule:
  - A selected write with rd==0 still consumes its slot (FIFO entry dequeued) but produces rf_wen=0. rf_rd and rf_data still update.
  - iss_valid with iss_rd==0 never sets pending[0]. pending[0] is constant 0.
- Scoreboard:
  - Set pending[iss_rd] on an edge with iss_valid.
  - Clear pending[rf_rd] on an edge where rf_wen=1, i.e. the same edge the register file commits.
  - Set and clear of the same index on the same edge: set wins.
  - Writes to a non-pending register are legal and leave it clear.
  - One pending bit per register, not a counter: issue logic must not issue a second writer to a pending register.
- ALU starvation: continuous alu_valid starves the FIFO indefinitely. This is intended; the LSU is stalled via lsu_ready.
- Protocol: the LSU must hold lsu_rd/lsu_data stable while lsu_valid && !lsu_ready. The unit does not check this.

Test Plan:
- Reset then idle -> rf_wen=0, pending=0, fifo_count=0, lsu_ready=1. Drop rst_n mid-run with 3 FIFO entries -> fifo_count=0 immediately, pending=0.
- iss x5; next cycle ALU valid rd=5 data=0xDEADBEEF -> rf_wen=1, rf_rd=5, rf_data=0xDEADBEEF one cycle later. pending[5] goes 1, then clears on the edge ending the rf_wen cycle.
- Concurrent ALU (rd=3, 0x11) and LSU (rd=4, 0x22) valid, FIFO empty -> write x3=0x11 first, then x4=0x22 in the next cycle. lsu_ready stays 1.
- Hold alu_valid for 6 cycles while LSU offers 6 results -> fifo_count reaches 4, lsu_ready=0 for the remainder. After the ALU stops, 4 writes drain in order, the remaining LSU results enqueue, and FIFO order is preserved across pointer wrap.
- ALU rd=0 data=0x55 -> rf_wen stays 0, pending unchanged. iss_valid rd=0 -> pending[0] stays 0.
- iss_valid rd=7 on the same edge that rf_wen=1, rf_rd=7 commits -> pending[7]=1 afterwards.

Source files
------------

// File: rtl/writeback_unit.sv
// Register file write-port initiator: merges ALU and buffered LSU results into
// one registered write per cycle and maintains the per-register pending scoreboard.
module writeback_unit #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        iss_valid,
  input  logic [ADDR_WIDTH-1:0]       iss_rd,
  input  logic                        alu_valid,
  input  logic [ADDR_WIDTH-1:0]       alu_rd,
  input  logic [DATA_WIDTH-1:0]       alu_data,
  input  logic                        lsu_valid,
  output logic                        lsu_ready,
  input  logic [ADDR_WIDTH-1:0]       lsu_rd,
  input  logic [DATA_WIDTH-1:0]       lsu_data,
  output logic                        rf_wen,
  output logic [ADDR_WIDTH-1:0]       rf_rd,
  output logic [DATA_WIDTH-1:0]       rf_data,
  output logic [(2**ADDR_WIDTH)-1:0]  pending,
  output logic [$clog2(DEPTH):0]      fifo_count
);

  localparam int unsigned NREG  = 2 ** ADDR_WIDTH;
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] mem_rd   [DEPTH];
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  logic                  full;
  logic                  empty;
  logic                  enq;
  logic                  deq;
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [NREG-1:0]       pending_next;

  assign full      = (fifo_count == CNT_W'(DEPTH));
  assign empty     = (fifo_count == '0);
  assign lsu_ready = !full;
  assign enq       = lsu_valid && !full;
  // The ALU has priority; the FIFO head only drains on ALU-idle cycles.
  assign deq       = !alu_valid && !empty;
  assign sel_valid = alu_valid || !empty;
  assign sel_rd    = alu_valid ? alu_rd   : mem_rd[rd_ptr];
  assign sel_data  = alu_valid ? alu_data : mem_data[rd_ptr];

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_rd[wr_ptr]   <= lsu_rd;
      mem_data[wr_ptr] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
      if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Registered write port; x0 writes consume the slot but never assert wen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen  <= 1'b0;
      rf_rd   <= '0;
      rf_data <= '0;
    end else begin
      rf_wen <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        rf_rd   <= sel_rd;
        rf_data <= sel_data;
      end
    end
  end

  // Clear on commit, then set on issue so a same-edge set wins.
  always_comb begin
    pending_next = pending;
    if (rf_wen)    pending_next[rf_rd]  = 1'b0;
    if (iss_valid) pending_next[iss_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_next;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed scenarios plus random traffic
// checked against a queue-based behavioural model.
module tb_writeback_unit;

  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NREG  = 2 ** AW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            alu_valid;
  logic [AW-1:0]   alu_rd;
  logic [DW-1:0]   alu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [DW-1:0]   lsu_data;
  logic            rf_wen;
  logic [AW-1:0]   rf_rd;
  logic [DW-1:0]   rf_data;
  logic [NREG-1:0] pending;
  logic [$clog2(DEPTH):0] fifo_count;

  writeback_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: pending results waiting in LSU order, scoreboard bits, and the write on the port.
  logic [AW+DW-1:0] m_q[$];
  logic [NREG-1:0]  m_pend;
  logic             m_wen;
  logic [AW-1:0]    m_rd;
  logic [DW-1:0]    m_data;
  logic [AW+DW-1:0] obs_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pend = '0;
    m_wen  = 1'b0;
    m_rd   = '0;
    m_data = '0;
  endtask

  task automatic model_edge();
    bit            ready;
    bit            sel;
    logic [AW-1:0] srd;
    logic [DW-1:0] sdat;
    ready = (m_q.size() < DEPTH);
    sel   = 1'b0;
    srd   = '0;
    sdat  = '0;
    if (alu_valid) begin
      sel = 1'b1; srd = alu_rd; sdat = alu_data;
    end else if (m_q.size() > 0) begin
      sel = 1'b1; {srd, sdat} = m_q.pop_front();
    end
    if (m_wen) m_pend[m_rd] = 1'b0;
    if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    if (lsu_valid && ready) m_q.push_back({lsu_rd, lsu_data});
    m_wen = sel && (srd != 0);
    if (sel) begin
      m_rd = srd; m_data = sdat;
    end
  endtask

  task automatic check_all();
    chk("lsu_ready", 64'(lsu_ready), 64'(m_q.size() < DEPTH));
    chk("fifo_count", 64'(fifo_count), 64'(m_q.size()));
    chk("pending", 64'(pending), 64'(m_pend));
    chk("rf_wen", 64'(rf_wen), 64'(m_wen));
    if (m_wen) begin
      chk("rf_rd", 64'(rf_rd), 64'(m_rd));
      chk("rf_data", 64'(rf_data), 64'(m_data));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
    if (rf_wen) obs_log.push_back({rf_rd, rf_data});
  endtask

  task automatic idle_inputs();
    iss_valid = 1'b0; iss_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
  endtask

  initial begin
    int k;
    int seen;
    bit rdy;
    logic [NREG-1:0] snap;
    logic [AW+DW-1:0] e;

    // Reset and idle
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #22;
    chk("rst_rf_wen", 64'(rf_wen), 64'd0);
    chk("rst_rf_rd", 64'(rf_rd), 64'd0);
    chk("rst_rf_data", 64'(rf_data), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    rst_n = 1'b1;
    step();
    step();

    // Issue x5, ALU writes it, pending clears at the end of the wen cycle
    iss_valid = 1'b1; iss_rd = 5'd5;
    step();
    chk("iss5_pending", 64'(pending[5]), 64'd1);
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu5_wen", 64'(rf_wen), 64'd1);
    chk("alu5_rd", 64'(rf_rd), 64'd5);
    chk("alu5_data", 64'(rf_data), 64'hDEADBEEF);
    chk("alu5_pending_held", 64'(pending[5]), 64'd1);
    idle_inputs();
    step();
    chk("alu5_pending_clr", 64'(pending[5]), 64'd0);
    chk("alu5_wen_drop", 64'(rf_wen), 64'd0);

    // Concurrent ALU and LSU with empty FIFO
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h22;
    chk("conc_ready_pre", 64'(lsu_ready), 64'd1);
    step();
    chk("conc_first_rd", 64'(rf_rd), 64'd3);
    chk("conc_first_data", 64'(rf_data), 64'h11);
    chk("conc_ready_mid", 64'(lsu_ready), 64'd1);
    idle_inputs();
    step();
    chk("conc_second_wen", 64'(rf_wen), 64'd1);
    chk("conc_second_rd", 64'(rf_rd), 64'd4);
    chk("conc_second_data", 64'(rf_data), 64'h22);
    step();

    // ALU starvation fills the FIFO; drain keeps LSU order across the wrap
    obs_log.delete();
    k = 0;
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rd = AW'(20 + c); alu_data = 32'h1000 + 32'(c);
      lsu_valid = 1'b1; lsu_rd = AW'(8 + k); lsu_data = 32'hA0 + 32'(k);
      rdy = (m_q.size() < DEPTH);
      step();
      if (rdy) k++;
    end
    chk("starve_count", 64'(fifo_count), 64'd4);
    chk("starve_ready", 64'(lsu_ready), 64'd0);
    alu_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (k < 6) begin
        lsu_valid = 1'b1; lsu_rd = AW'(8 + k); lsu_data = 32'hA0 + 32'(k);
      end else begin
        lsu_valid = 1'b0;
      end
      rdy = (m_q.size() < DEPTH);
      step();
      if (rdy && lsu_valid) k++;
    end
    seen = 0;
    foreach (obs_log[i]) begin
      e = obs_log[i];
      if (e[AW+DW-1:DW] >= AW'(8) && e[AW+DW-1:DW] <= AW'(13)) begin
        chk("drain_order", 64'(e[DW-1:0]), 64'(32'hA0 + 32'(seen)));
        seen++;
      end
    end
    chk("drain_total", 64'(seen), 64'd6);
    idle_inputs();

    // x0 writes and x0 issue
    snap = pending;
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    step();
    chk("x0_wen", 64'(rf_wen), 64'd0);
    chk("x0_rd", 64'(rf_rd), 64'd0);
    chk("x0_data", 64'(rf_data), 64'h55);
    chk("x0_pending", 64'(pending), 64'(snap));
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd0;
    step();
    chk("x0_iss_pending0", 64'(pending[0]), 64'd0);
    idle_inputs();

    // Same-edge set and clear of x7: set wins
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    idle_inputs();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
    step();
    chk("x7_wen", 64'(rf_wen), 64'd1);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    chk("x7_set_wins", 64'(pending[7]), 64'd1);
    idle_inputs();

    // Mid-run reset with three buffered LSU results
    iss_valid = 1'b1; iss_rd = 5'd9;
    step();
    iss_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'(c);
      lsu_valid = 1'b1; lsu_rd = AW'(16 + c); lsu_data = 32'hB0 + 32'(c);
      step();
    end
    chk("prerst_count", 64'(fifo_count), 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_count", 64'(fifo_count), 64'd0);
    chk("midrst_pending", 64'(pending), 64'd0);
    chk("midrst_ready", 64'(lsu_ready), 64'd1);
    chk("midrst_wen", 64'(rf_wen), 64'd0);
    idle_inputs();
    #10;
    rst_n = 1'b1;
    step();
    step();

    // Random traffic; LSU fields only change when not stalled
    for (int c = 0; c < 400; c++) begin
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = AW'($urandom);
      alu_valid = ($urandom_range(0, 99) < 40);
      alu_rd    = AW'($urandom);
      alu_data  = $urandom;
      if (!lsu_valid || (m_q.size() < DEPTH)) begin
        lsu_valid = ($urandom_range(0, 99) < 60);
        lsu_rd    = AW'($urandom);
        lsu_data  = $urandom;
      end
      step();
    end
    idle_inputs();
    for (int c = 0; c < 6; c++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
